// File: rtl/toy_bus_pkg.sv
// Shared types and constants for the toy bus peripheral arbiter.
package toy_bus_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERR_ACK  = 2'd2
    } arb_state_e;

    // Request opcodes
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Ack opcodes
    localparam logic ACK_OK   = 1'b0;
    localparam logic ACK_ERR  = 1'b1;

    // Data returned with a synthesized timeout ack
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Request beat at the default node widths
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        opcode;
        logic [3:0]  src_id;
    } req_t;

    // Ack beat at the default node widths
    typedef struct packed {
        logic        opcode;
        logic [31:0] data;
        logic [3:0]  tgt_id;
    } ack_t;

endpackage

// File: rtl/toy_bus_rr_pick.sv
// Round-robin priority picker: first asserted request at or above i_ptr,
// wrapping at N. Returns the choice as one-hot and as an index.
module toy_bus_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_slot;

    // Scan offsets from farthest to nearest so the slot nearest the pointer wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_sum  = '0;
        w_slot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(N)) begin
                w_sum = w_sum - (IW + 1)'(N);
            end else begin
                w_sum = w_sum;
            end
            w_slot = w_sum[IW-1:0];
            if (i_req[w_slot]) begin
                o_gnt         = '0;
                o_gnt[w_slot] = 1'b1;
                o_idx         = w_slot;
            end else begin
                // keep the candidate found so far
            end
        end
    end

endmodule

// File: rtl/toy_bus_periph_arb.sv
// Round-robin arbiter sharing one peripheral bus node between N_IN requesters.
// Holds the grant across a stalled request and across an outstanding read,
// routes the read ack back to its issuer, and synthesizes an error ack when
// the peripheral does not answer within TIMEOUT cycles.
module toy_bus_periph_arb #(
    parameter int N_IN    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          in_req_vld,
    output logic [N_IN-1:0]          in_req_rdy,
    input  logic [N_IN*ADDR_W-1:0]   in_req_addr,
    input  logic [N_IN*DATA_W-1:0]   in_req_data,
    input  logic [N_IN*4-1:0]        in_req_strb,
    input  logic [N_IN-1:0]          in_req_opcode,
    input  logic [N_IN*ID_W-1:0]     in_req_src_id,
    output logic [N_IN-1:0]          in_ack_vld,
    input  logic [N_IN-1:0]          in_ack_rdy,
    output logic                     in_ack_opcode,
    output logic [DATA_W-1:0]        in_ack_data,
    output logic [ID_W-1:0]          in_ack_tgt_id,
    output logic                     out_req_vld,
    input  logic                     out_req_rdy,
    output logic [ADDR_W-1:0]        out_req_addr,
    output logic [DATA_W-1:0]        out_req_data,
    output logic [3:0]               out_req_strb,
    output logic                     out_req_opcode,
    output logic [ID_W-1:0]          out_req_src_id,
    input  logic                     out_ack_vld,
    output logic                     out_ack_rdy,
    input  logic [DATA_W-1:0]        out_ack_data,
    output logic [7:0]               stray_cnt
);
    import toy_bus_pkg::*;

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // State and registers
    arb_state_e     r_state;
    logic [IW-1:0]  r_rr_ptr;
    logic           r_lock;
    logic [IW-1:0]  r_owner;
    logic [ID_W-1:0] r_owner_id;
    logic [TW-1:0]  r_to_cnt;
    logic [7:0]     r_stray_cnt;

    // Next-state values
    arb_state_e     w_state_nx;
    logic [IW-1:0]  w_rr_ptr_nx;
    logic           w_lock_nx;
    logic [IW-1:0]  w_owner_nx;
    logic [ID_W-1:0] w_owner_id_nx;
    logic [TW-1:0]  w_to_cnt_nx;
    logic [7:0]     w_stray_nx;
    logic           w_stray_hit;

    // Arbitration
    logic [N_IN-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic [IW-1:0]   w_win_idx;
    logic [N_IN-1:0] w_win_oh;
    logic            w_any;

    // Unpacked payload views
    logic [ADDR_W-1:0] w_addr [N_IN];
    logic [DATA_W-1:0] w_data [N_IN];
    logic [3:0]        w_strb [N_IN];
    logic [ID_W-1:0]   w_src  [N_IN];

    toy_bus_rr_pick #(
        .N  (N_IN),
        .IW (IW)
    ) u_pick (
        .i_req (in_req_vld),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    // Split the packed per-requester payload buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_addr[i] = in_req_addr[i*ADDR_W +: ADDR_W];
            w_data[i] = in_req_data[i*DATA_W +: DATA_W];
            w_strb[i] = in_req_strb[i*4 +: 4];
            w_src[i]  = in_req_src_id[i*ID_W +: ID_W];
        end
    end

    // A stalled grant is frozen on the locked owner until its handshake completes.
    assign w_any     = |in_req_vld;
    assign w_win_idx = r_lock ? r_owner : w_pick_idx;
    assign w_win_oh  = r_lock ? (N_IN'(1'b1) << r_owner) : w_pick_gnt;

    assign out_req_addr   = w_addr[w_win_idx];
    assign out_req_data   = w_data[w_win_idx];
    assign out_req_strb   = w_strb[w_win_idx];
    assign out_req_opcode = in_req_opcode[w_win_idx];
    assign out_req_src_id = w_src[w_win_idx];
    assign stray_cnt      = r_stray_cnt;

    // Next-state, handshake and ack-routing decode.
    always_comb begin
        w_state_nx    = r_state;
        w_rr_ptr_nx   = r_rr_ptr;
        w_lock_nx     = r_lock;
        w_owner_nx    = r_owner;
        w_owner_id_nx = r_owner_id;
        w_to_cnt_nx   = r_to_cnt;
        w_stray_nx    = r_stray_cnt;
        w_stray_hit   = 1'b0;
        out_req_vld   = 1'b0;
        in_req_rdy    = '0;
        in_ack_vld    = '0;
        in_ack_opcode = ACK_OK;
        in_ack_data   = '0;
        in_ack_tgt_id = '0;
        out_ack_rdy   = 1'b1;

        case (r_state)
            IDLE: begin
                out_req_vld = w_any;
                // No read is outstanding, so any peripheral ack here is unexpected.
                w_stray_hit = out_ack_vld;
                if (w_any && !out_req_rdy) begin
                    w_lock_nx  = 1'b1;
                    w_owner_nx = w_win_idx;
                end else if (w_any && out_req_rdy) begin
                    in_req_rdy = w_win_oh;
                    w_lock_nx  = 1'b0;
                    if (w_win_idx == IW'(N_IN - 1)) begin
                        w_rr_ptr_nx = '0;
                    end else begin
                        w_rr_ptr_nx = w_win_idx + IW'(1);
                    end
                    if (in_req_opcode[w_win_idx] == OP_READ) begin
                        w_owner_nx    = w_win_idx;
                        w_owner_id_nx = w_src[w_win_idx];
                        w_to_cnt_nx   = '0;
                        w_state_nx    = WAIT_ACK;
                    end else begin
                        w_state_nx    = IDLE;
                    end
                end else begin
                    w_lock_nx = r_lock;
                end
            end

            WAIT_ACK: begin
                in_ack_vld[r_owner] = out_ack_vld;
                out_ack_rdy         = in_ack_rdy[r_owner];
                if (out_ack_vld) begin
                    // A real ack wins even in the final timeout cycle.
                    in_ack_data   = out_ack_data;
                    in_ack_tgt_id = r_owner_id;
                    if (in_ack_rdy[r_owner]) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = WAIT_ACK;
                    end
                end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                    w_state_nx = ERR_ACK;
                end else begin
                    w_to_cnt_nx = r_to_cnt + TW'(1);
                end
            end

            ERR_ACK: begin
                in_ack_vld[r_owner] = 1'b1;
                in_ack_opcode       = ACK_ERR;
                in_ack_data         = DATA_W'(ERR_DATA);
                in_ack_tgt_id       = r_owner_id;
                // The read was already answered with an error; a late ack is dropped.
                w_stray_hit         = out_ack_vld;
                if (in_ack_rdy[r_owner]) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = ERR_ACK;
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (w_stray_hit && (r_stray_cnt != 8'hFF)) begin
            w_stray_nx = r_stray_cnt + 8'd1;
        end else begin
            w_stray_nx = r_stray_cnt;
        end
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_owner     <= '0;
            r_owner_id  <= '0;
            r_to_cnt    <= '0;
            r_stray_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_lock      <= w_lock_nx;
            r_owner     <= w_owner_nx;
            r_owner_id  <= w_owner_id_nx;
            r_to_cnt    <= w_to_cnt_nx;
            r_stray_cnt <= w_stray_nx;
        end
    end

endmodule
